// File: rtl/cmp_seq_ctrl.sv
// Sequential magnitude comparator: one greater/less cell walks the operand
// pair LSB first, one bit per clock, and reports gt/lt/eq after WIDTH cycles.
module cmp_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   xs_r;
    logic [WIDTH-1:0]   ys_r;
    logic               sm_r;
    logic               g_r;
    logic               l_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               gt_r;
    logic               lt_r;
    logic               eq_r;

    logic               accept_s;
    logic               step_s;
    logic               finish_s;
    logic               clear_s;
    logic               last_bit_s;
    logic               swap_s;
    logic               xb_s;
    logic               yb_s;
    logic               g_next_s;
    logic               l_next_s;

    // A differing higher bit overrides whatever the lower bits decided.
    function automatic logic [1:0] cmp_cell(input logic xb, input logic yb,
                                            input logic g, input logic l);
        logic g_n;
        logic l_n;
        g_n = (xb & ~yb) | (g & ~l & ~(~xb & yb));
        l_n = (~xb & yb) | (l & ~g & ~(xb & ~yb));
        return {g_n, l_n};
    endfunction

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    // The sign bit carries inverted weight, so swapping makes a negative operand the smaller.
    assign swap_s     = sm_r & last_bit_s;
    assign xb_s       = swap_s ? ys_r[0] : xs_r[0];
    assign yb_s       = swap_s ? xs_r[0] : ys_r[0];
    assign {g_next_s, l_next_s} = cmp_cell(xb_s, yb_s, g_r, l_r);

    assign busy = busy_r;
    assign done = done_r;
    assign gt   = gt_r;
    assign lt   = lt_r;
    assign eq   = eq_r;

    // Next-state and per-cycle control decode; abort has priority over start.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (last_bit_s) begin
                    step_s       = 1'b1;
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    step_s       = 1'b1;
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shifters, running G/L, bit counter and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs_r   <= {WIDTH{1'b0}};
            ys_r   <= {WIDTH{1'b0}};
            sm_r   <= 1'b0;
            g_r    <= 1'b0;
            l_r    <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
            eq_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= finish_s;
            if (accept_s) begin
                xs_r  <= x;
                ys_r  <= y;
                sm_r  <= signed_mode;
                g_r   <= 1'b0;
                l_r   <= 1'b0;
                cnt_r <= {CNT_W{1'b0}};
                gt_r  <= 1'b0;
                lt_r  <= 1'b0;
                eq_r  <= 1'b0;
            end else if (step_s) begin
                xs_r  <= {1'b0, xs_r[WIDTH-1:1]};
                ys_r  <= {1'b0, ys_r[WIDTH-1:1]};
                g_r   <= g_next_s;
                l_r   <= l_next_s;
                cnt_r <= cnt_r + CNT_W'(1);
                if (finish_s) begin
                    gt_r <= g_next_s;
                    lt_r <= l_next_s;
                    eq_r <= ~g_next_s & ~l_next_s;
                end else begin
                    gt_r <= gt_r;
                end
            end else if (clear_s) begin
                gt_r <= 1'b0;
                lt_r <= 1'b0;
                eq_r <= 1'b0;
            end else begin
                gt_r <= gt_r;
            end
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: directed scenarios then randomized
// operand pairs, checked against an arithmetic compare model.
module tb_cmp_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic         abort;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;

    int   total = 0;
    int   bad   = 0;
    logic exp_gt;
    logic exp_lt;
    logic exp_eq;

    cmp_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .abort(abort), .x(x), .y(y), .busy(busy), .done(done),
        .gt(gt), .lt(lt), .eq(eq)
    );

    always #5 clk = ~clk;

    // Reference: compare as plain integers, sign-extended when signed.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic signed [W:0] ea;
        logic signed [W:0] eb;
        ea = s ? {a[W-1], a} : {1'b0, a};
        eb = s ? {b[W-1], b} : {1'b0, b};
        return {ea > eb, ea < eb, ea == eb};
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic smv);
        x = xv;
        y = yv;
        signed_mode = smv;
        start = 1'b1;
        {exp_gt, exp_lt, exp_eq} = ref_cmp(xv, yv, smv);
        tick();
        start = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Runs the WIDTH busy cycles; optionally pulses start at RUN cycle 'glitch'.
    task automatic complete(input int glitch);
        for (int i = 0; i < W; i++) begin
            chk("busy_run", busy, 1'b1);
            chk("done_early", done, 1'b0);
            if (i == glitch) begin
                start = 1'b1;
                x = W'($urandom);
                y = W'($urandom);
            end
            tick();
            start = 1'b0;
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("gt", gt, exp_gt);
        chk("lt", lt, exp_lt);
        chk("eq", eq, exp_eq);
    endtask

    task automatic hold_check();
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("gt_hold", gt, exp_gt);
        chk("lt_hold", lt, exp_lt);
        chk("eq_hold", eq, exp_eq);
    endtask

    task automatic quiet_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_done"}, done, 1'b0);
            chk({tag, "_busy"}, busy, 1'b0);
        end
    endtask

    task automatic zero_results(input string tag);
        chk({tag, "_gt"}, gt, 1'b0);
        chk({tag, "_lt"}, lt, 1'b0);
        chk({tag, "_eq"}, eq, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        signed_mode = 1'b0;
        x = '0;
        y = '0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        zero_results("rst");
        #10;
        reset = 1'b0;
        tick();

        // Directed compares
        accept(8'h40, 8'h3F, 1'b0); complete(-1); hold_check();
        accept(8'hA5, 8'hA5, 1'b0); complete(-1); hold_check();
        accept(8'h00, 8'hFF, 1'b0); complete(-1); hold_check();
        accept(8'h80, 8'h01, 1'b1); complete(-1); hold_check();
        chk("signed_lt", lt, 1'b1);
        accept(8'h80, 8'h01, 1'b0); complete(-1); hold_check();
        chk("unsigned_gt", gt, 1'b1);

        // Start during RUN is ignored
        accept(8'h01, 8'h02, 1'b0); complete(2); hold_check();

        // Abort during RUN
        accept(8'h01, 8'h02, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_pre_abort", busy, 1'b1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        zero_results("abort_run");
        quiet_check(W + 2, "post_abort");
        accept(8'h33, 8'h32, 1'b1); complete(-1); hold_check();

        // Abort from DONE clears results
        accept(8'h12, 8'h34, 1'b0); complete(-1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_state", done, 1'b0);
        zero_results("abort_done");

        // Abort wins over start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        quiet_check(2, "abort_start");

        // Back-to-back: start during DONE
        accept(8'h55, 8'h54, 1'b0); complete(-1);
        accept(8'h10, 8'h20, 1'b0); complete(-1); hold_check();
        chk("b2b_lt", lt, 1'b1);

        // Asynchronous reset mid-RUN
        accept(8'h7E, 8'h7F, 1'b0);
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        zero_results("arst");
        reset = 1'b0;
        quiet_check(W + 2, "post_arst");
        accept(8'hC3, 8'h3C, 1'b1); complete(-1); hold_check();

        // Randomized pairs, some back-to-back, some with ignored starts
        for (int n = 0; n < 40; n++) begin
            accept(W'($urandom), W'($urandom), 1'($urandom));
            complete(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
            if ($urandom_range(0, 1) == 1) hold_check();
        end
        hold_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
